blk_seq_ctrl: RTL and testbench
===============================

# blk_seq_ctrl

Sequencer and memory-port arbiter for the SABER compute blocks such as the timer loop and the multiplier/sampler cores. It holds every block in reset and releases the selected blocks one at a time, in ascending index order. While a block runs, it owns the shared data-memory read address. The controller waits for that block's level `done`, then re-resets it and moves to the next block, with a watchdog to abort hung blocks.

## Interface
Parameters:
- `NBLK`, 4: number of sequenced blocks.
- `ADDR_W`, 9: memory address width.
- `WD_W`, 33: watchdog counter/limit width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `go`, in, 1: start request. Sampled only in IDLE, FIN or ERR.
- `run_mask`, in, NBLK: blocks to run. Captured on an accepted `go`.
- `wd_limit`, in, WD_W: per-block cycle limit in RUN. 0 disables the watchdog.
- `busy`, out, 1: high in SEL, RST, RUN and DRAIN.
- `done`, out, 1: high in FIN. Holds until the next accepted `go`.
- `error`, out, 1: high in ERR. Holds until the next accepted `go`.
- `err_blk`, out, $clog2(NBLK): index of the block that timed out. Valid while `error` is high.
- `blk_rst`, out, NBLK: per-block synchronous reset, registered.
- `blk_done`, in, NBLK: per-block level done.
- `blk_addr`, in, NBLK*ADDR_W: packed per-block read addresses. Block i occupies bits [i*ADDR_W +: ADDR_W].
- `mem_addr`, out, ADDR_W: address to the shared memory. The memory read data is broadcast to all blocks outside this block.

## Operation
States: IDLE, SEL, RST, RUN, DRAIN, FIN, ERR.
- **IDLE**
  - On `go`: `pend` <= `run_mask`, clear `done`/`error`, go to SEL.
- **SEL**
  - If `pend` is 0, go to FIN.
  - Otherwise `cur` <= index of the lowest set bit of `pend`, clear the watchdog, go to RST.
- **RST**
  - `blk_rst[cur]` stays high for this one cycle. This guarantees a fresh reset even if the block ran earlier.
  - Go to RUN.
- **RUN**
  - `blk_rst[cur]` low. All other `blk_rst` bits high.
  - Watchdog increments every cycle.
  - If `blk_done[cur]` is high, go to DRAIN.
  - Else if `wd_limit` != 0 and watchdog == `wd_limit`, go to ERR with `err_blk` <= `cur`.
  - If done and timeout occur in the same cycle, done wins.
- **DRAIN**
  - `blk_rst[cur]` is high again.
  - `pend[cur]` <= 0, go to SEL.
- **FIN, ERR**
  - All `blk_rst` bits high.
  - A new `go` restarts exactly as from IDLE.
- `go` is ignored while `busy`. `run_mask` changes while `busy` have no effect.
- `blk_done` of non-current blocks is ignored.
- `mem_addr` = `blk_addr[cur]` in RST and RUN. It is 0 in every other state. The mux is combinational from `cur` and the state.
- Watchdog arithmetic is unsigned WD_W bits. It saturates and never wraps.

## Timing
- Reset values:
  - state IDLE.
  - `blk_rst` all 1.
  - `busy`, `done`, `error` 0.
  - `err_blk` 0, `pend` 0, `cur` 0, `mem_addr` 0.
- Reset asserted in any state returns to IDLE next cycle and re-asserts every `blk_rst`. There is no `done` or `error` pulse.
- Latency: `go` sampled at edge 0 gives:
  - SEL at edge 1.
  - RST at edge 2.
  - `blk_rst[cur]` low from edge 3.
- `blk_done[cur]` sampled high at edge k gives:
  - DRAIN at k, `blk_rst[cur]` high from k.
  - SEL at k+1.
  - Next block's `blk_rst` low at k+3.
- After the last block: FIN, and `done` high, 2 cycles after DRAIN is entered.
- Empty mask: `done` high 2 cycles after `go`.
- Per-block overhead is 4 cycles (SEL, RST, DRAIN, plus the done-detect edge).

## Structure
- Package `saber_ctrl_pkg` holds:
  - the state enum with explicit 3-bit encodings;
  - the default NBLK and ADDR_W localparams.
- One sub-module, `lsb_index`: a parameterised lowest-set-bit priority encoder that also outputs `none`. It is used by SEL.
- The FSM, watchdog and address mux live in the top module.

## Test plan
- **Single block:** `run_mask`=4'b0010; block 1 raises done 20 cycles after release.
  - `blk_rst[1]` is low for exactly 21 cycles.
  - `done` rises 2 cycles after DRAIN; `error`=0.
- **Sequential order:** `run_mask`=4'b1011.
  - Blocks are released in the order 0, 1, 3, never overlapping.
  - `mem_addr` tracks `blk_addr[0]`, then `[1]`, then `[3]`, and is 0 between blocks.
- **Empty mask:** `go` with 4'b0000.
  - `done` is high at edge 2.
  - `blk_rst` stays 4'b1111 throughout.
- **Watchdog:** `wd_limit`=10; block 2 never raises done.
  - ERR after 10 RUN cycles, `err_blk`=2, `blk_rst`=4'b1111.
  - A following `go` clears `error` and restarts.
  - With `wd_limit`=0 the run never times out.
- **Done and timeout same cycle:** `blk_done` rises on the cycle where the watchdog hits the limit.
  - DRAIN is taken; `error`=0.
- **Abort and ignored inputs:** `rst` pulsed mid-RUN of block 1.
  - IDLE next cycle, all `blk_rst` high, no `done`.
  - `go` pulses while `busy` are ignored.
  - Stray `blk_done[3]` while block 0 runs is ignored.

Source files
------------

// File: rtl/blk_seq_ctrl_pkg.sv
// Shared types and defaults for the SABER block sequencer.
package saber_ctrl_pkg;

  localparam int unsigned NBLK_DEF   = 4;
  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned WD_W_DEF   = 33;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_RST   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5,
    S_ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/blk_seq_ctrl_if.sv
// Control, status and per-block memory-port signals of the sequencer.
interface blk_seq_ctrl_if
  import saber_ctrl_pkg::*;
#(
  parameter int unsigned NBLK   = NBLK_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned WD_W   = WD_W_DEF
);
  localparam int unsigned IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  logic                   go;
  logic [NBLK-1:0]        run_mask;
  logic [WD_W-1:0]        wd_limit;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [IDX_W-1:0]       err_blk;
  logic [NBLK-1:0]        blk_rst;
  logic [NBLK-1:0]        blk_done;
  logic [NBLK*ADDR_W-1:0] blk_addr;
  logic [ADDR_W-1:0]      mem_addr;

  modport master (
    output go, run_mask, wd_limit, blk_done, blk_addr,
    input  busy, done, error, err_blk, blk_rst, mem_addr
  );

  modport slave (
    input  go, run_mask, wd_limit, blk_done, blk_addr,
    output busy, done, error, err_blk, blk_rst, mem_addr
  );

endinterface

// File: rtl/blk_seq_ctrl_lsb_index.sv
// Lowest-set-bit priority encoder; o_none flags an all-zero vector.
module lsb_index #(
  parameter int unsigned W     = 4,
  parameter int unsigned IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_none
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_idx  = '0;
    o_none = (i_vec == '0);
    for (int unsigned i = 0; i < W; i++) begin
      if (i_vec[W-1-i]) o_idx = IDX_W'(W - 1 - i);
    end
  end

endmodule

// File: rtl/blk_seq_ctrl.sv
// Sequencer/arbiter: releases selected blocks one at a time in ascending
// order, muxes the running block's read address, aborts hung blocks.
module blk_seq_ctrl
  import saber_ctrl_pkg::*;
#(
  parameter int unsigned NBLK   = NBLK_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned WD_W   = WD_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  blk_seq_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  state_t           r_state, w_next;
  logic [NBLK-1:0]  r_pend, w_pend_nxt;
  logic [NBLK-1:0]  r_blk_rst, w_blk_rst_nxt;
  logic [IDX_W-1:0] r_cur, w_cur_nxt;
  logic [IDX_W-1:0] r_err_blk, w_err_blk_nxt;
  logic [WD_W-1:0]  r_wd, w_wd_nxt, w_wd_inc;
  logic [IDX_W-1:0] w_lsb;
  logic             w_none;
  logic             w_cur_done;
  logic             w_timeout;

  lsb_index #(.W(NBLK), .IDX_W(IDX_W)) u_lsb (
    .i_vec  (r_pend),
    .o_idx  (w_lsb),
    .o_none (w_none)
  );

  // Watchdog compares the count including the current RUN cycle.
  assign w_wd_inc   = (r_wd == '1) ? r_wd : r_wd + WD_W'(1);
  assign w_cur_done = bus.blk_done[r_cur];
  assign w_timeout  = (bus.wd_limit != '0) && (w_wd_inc == bus.wd_limit);

  always_comb begin
    w_next        = r_state;
    w_pend_nxt    = r_pend;
    w_cur_nxt     = r_cur;
    w_err_blk_nxt = r_err_blk;
    w_wd_nxt      = r_wd;
    unique case (r_state)
      S_IDLE, S_FIN, S_ERR: begin
        if (bus.go) begin
          w_pend_nxt = bus.run_mask;
          w_next     = S_SEL;
        end
      end
      S_SEL: begin
        if (w_none) begin
          w_next = S_FIN;
        end else begin
          w_cur_nxt = w_lsb;
          w_wd_nxt  = '0;
          w_next    = S_RST;
        end
      end
      S_RST: w_next = S_RUN;
      S_RUN: begin
        w_wd_nxt = w_wd_inc;
        if (w_cur_done) begin
          w_next = S_DRAIN;
        end else if (w_timeout) begin
          w_next        = S_ERR;
          w_err_blk_nxt = r_cur;
        end
      end
      S_DRAIN: begin
        w_pend_nxt[r_cur] = 1'b0;
        w_next            = S_SEL;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Block resets are registered from the next state so release aligns with RUN.
  always_comb begin
    w_blk_rst_nxt = '1;
    if (w_next == S_RUN) w_blk_rst_nxt[r_cur] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pend    <= '0;
      r_cur     <= '0;
      r_err_blk <= '0;
      r_wd      <= '0;
      r_blk_rst <= '1;
    end else begin
      r_state   <= w_next;
      r_pend    <= w_pend_nxt;
      r_cur     <= w_cur_nxt;
      r_err_blk <= w_err_blk_nxt;
      r_wd      <= w_wd_nxt;
      r_blk_rst <= w_blk_rst_nxt;
    end
  end

  assign bus.busy     = (r_state == S_SEL) || (r_state == S_RST) ||
                        (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done     = (r_state == S_FIN);
  assign bus.error    = (r_state == S_ERR);
  assign bus.err_blk  = r_err_blk;
  assign bus.blk_rst  = r_blk_rst;
  assign bus.mem_addr = ((r_state == S_RST) || (r_state == S_RUN)) ?
                        bus.blk_addr[r_cur*ADDR_W +: ADDR_W] : '0;

endmodule

// File: tb/tb_blk_seq_ctrl.sv
// Bench for blk_seq_ctrl: behavioural blocks plus an expected-timeline model.
module tb_blk_seq_ctrl;
  import saber_ctrl_pkg::*;

  localparam int unsigned NBLK   = 4;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned WD_W   = 33;
  localparam int          NEVER  = 1000000;
  localparam int          MAXC   = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blk_seq_ctrl_if #(.NBLK(NBLK), .ADDR_W(ADDR_W), .WD_W(WD_W)) bus ();

  blk_seq_ctrl #(.NBLK(NBLK), .ADDR_W(ADDR_W), .WD_W(WD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural blocks: raise done once they have spent dly cycles out of reset.
  int              dly [NBLK];
  int              cnt [NBLK];
  logic [NBLK-1:0] stray;

  always @(posedge clk) begin
    for (int i = 0; i < NBLK; i++)
      cnt[i] <= bus.blk_rst[i] ? 0 : ((cnt[i] < NEVER) ? cnt[i] + 1 : cnt[i]);
  end

  always_comb begin
    bus.blk_done = '0;
    for (int i = 0; i < NBLK; i++)
      bus.blk_done[i] = (cnt[i] >= dly[i]) || (stray[i] && bus.blk_rst[i]);
  end

  // Expected timeline, indexed by clock edges after the accepted go.
  bit              m_busy [MAXC];
  bit              m_done [MAXC];
  bit              m_err  [MAXC];
  logic [NBLK-1:0] m_rst  [MAXC];
  int              m_ablk [MAXC];
  int              m_eblk [MAXC];
  int              m_len;

  int obs_low [NBLK];
  int obs_order[$];

  task automatic put(input int c, input bit b, input bit dn, input bit er,
                     input logic [NBLK-1:0] r, input int ab, input int eb);
    m_busy[c] = b; m_done[c] = dn; m_err[c] = er;
    m_rst[c] = r; m_ablk[c] = ab; m_eblk[c] = eb;
  endtask

  task automatic build_model(input logic [NBLK-1:0] mask, input logic [WD_W-1:0] wd);
    int s, r, e;
    bit tmo;
    s = 0;
    put(0, 1, 0, 0, '1, -1, 0);
    for (int i = 0; i < NBLK; i++) begin
      if (!mask[i]) continue;
      put(s + 1, 1, 0, 0, '1, i, 0);
      r   = s + 2;
      tmo = (wd != '0) && (wd <= WD_W'(dly[i]));
      e   = tmo ? r + int'(wd) : r + dly[i] + 1;
      for (int c = r; c < e; c++) put(c, 1, 0, 0, ~(NBLK'(1) << i), i, 0);
      if (tmo) begin
        for (int c = e; c < e + 3; c++) put(c, 0, 0, 1, '1, -1, i);
        m_len = e + 3;
        return;
      end
      put(e, 1, 0, 0, '1, -1, 0);
      s = e + 1;
      put(s, 1, 0, 0, '1, -1, 0);
    end
    for (int c = s + 1; c < s + 4; c++) put(c, 0, 1, 0, '1, -1, 0);
    m_len = s + 4;
  endtask

  task automatic randomize_side_inputs();
    for (int i = 0; i < NBLK; i++) bus.blk_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    stray = NBLK'($urandom);
  endtask

  task automatic run_seq(input logic [NBLK-1:0] mask, input logic [WD_W-1:0] wd,
                         input int abort_blk, input int go_pct);
    int              abort_at;
    logic [NBLK-1:0] prev_rst;
    logic [ADDR_W-1:0] exp_addr;
    build_model(mask, wd);
    abort_at = -1;
    if (abort_blk >= 0) begin
      for (int n = 0; n < m_len; n++)
        if (abort_at < 0 && m_rst[n][abort_blk] == 1'b0) abort_at = n + 3;
    end
    for (int i = 0; i < NBLK; i++) obs_low[i] = 0;
    obs_order.delete();
    prev_rst     = bus.blk_rst;
    bus.wd_limit = wd;
    bus.go       = 1'b1;
    bus.run_mask = mask;
    for (int n = 0; n < m_len; n++) begin
      if (n == abort_at) rst = 1'b1;
      @(posedge clk); #1;
      if (n == abort_at) begin
        rst = 1'b0; bus.go = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          n_vec += 4;
          if (bus.busy !== 1'b0)  begin n_err++; $display("FAIL abort_busy k=%0d got %b exp 0", k, bus.busy); end
          if (bus.done !== 1'b0)  begin n_err++; $display("FAIL abort_done k=%0d got %b exp 0", k, bus.done); end
          if (bus.blk_rst !== '1) begin n_err++; $display("FAIL abort_blk_rst k=%0d got %b exp 1111", k, bus.blk_rst); end
          if (bus.mem_addr !== '0) begin n_err++; $display("FAIL abort_mem_addr k=%0d got %0h exp 0", k, bus.mem_addr); end
          @(posedge clk); #1;
        end
        @(negedge clk);
        return;
      end
      randomize_side_inputs();
      @(negedge clk);
      exp_addr = '0;
      if (m_ablk[n] >= 0) exp_addr = bus.blk_addr[m_ablk[n]*ADDR_W +: ADDR_W];
      n_vec += 5;
      if (bus.busy !== m_busy[n])
        begin n_err++; $display("FAIL busy n=%0d got %b exp %b", n, bus.busy, m_busy[n]); end
      if (bus.done !== m_done[n])
        begin n_err++; $display("FAIL done n=%0d got %b exp %b", n, bus.done, m_done[n]); end
      if (bus.error !== m_err[n])
        begin n_err++; $display("FAIL error n=%0d got %b exp %b", n, bus.error, m_err[n]); end
      if (bus.blk_rst !== m_rst[n])
        begin n_err++; $display("FAIL blk_rst n=%0d got %b exp %b", n, bus.blk_rst, m_rst[n]); end
      if (bus.mem_addr !== exp_addr)
        begin n_err++; $display("FAIL mem_addr n=%0d got %0h exp %0h", n, bus.mem_addr, exp_addr); end
      if (m_err[n]) begin
        n_vec++;
        if (int'(bus.err_blk) != m_eblk[n])
          begin n_err++; $display("FAIL err_blk n=%0d got %0d exp %0d", n, bus.err_blk, m_eblk[n]); end
      end
      for (int i = 0; i < NBLK; i++) begin
        if (!bus.blk_rst[i]) obs_low[i]++;
        if (prev_rst[i] && !bus.blk_rst[i]) obs_order.push_back(i);
      end
      prev_rst     = bus.blk_rst;
      bus.go       = m_busy[n] && ($urandom_range(99) < go_pct);
      bus.run_mask = NBLK'($urandom);
    end
    bus.go = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.go = 1'b0; bus.run_mask = '0; bus.wd_limit = '0;
    bus.blk_addr = '0; stray = '0;
    for (int i = 0; i < NBLK; i++) dly[i] = NEVER;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec += 6;
    if (bus.busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    if (bus.done !== 1'b0)     begin n_err++; $display("FAIL reset_done got %b exp 0", bus.done); end
    if (bus.error !== 1'b0)    begin n_err++; $display("FAIL reset_error got %b exp 0", bus.error); end
    if (bus.err_blk !== '0)    begin n_err++; $display("FAIL reset_err_blk got %0d exp 0", bus.err_blk); end
    if (bus.blk_rst !== '1)    begin n_err++; $display("FAIL reset_blk_rst got %b exp 1111", bus.blk_rst); end
    if (bus.mem_addr !== '0)   begin n_err++; $display("FAIL reset_mem_addr got %0h exp 0", bus.mem_addr); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_single_block();
    dly = '{NEVER, 20, NEVER, NEVER};
    run_seq(4'b0010, '0, -1, 30);
    n_vec += 3;
    if (obs_low[1] != 21) begin n_err++; $display("FAIL single_low_cycles got %0d exp 21", obs_low[1]); end
    if (obs_order.size() != 1) begin n_err++; $display("FAIL single_releases got %0d exp 1", obs_order.size()); end
    if (bus.done !== 1'b1 || bus.error !== 1'b0)
      begin n_err++; $display("FAIL single_final got done=%b error=%b exp done=1 error=0", bus.done, bus.error); end
  endtask

  task automatic test_sequential();
    dly = '{int'($urandom_range(12, 1)), int'($urandom_range(12, 1)), 1, int'($urandom_range(12, 1))};
    run_seq(4'b1011, '0, -1, 30);
    n_vec++;
    if (obs_order.size() != 3 || obs_order[0] != 0 || obs_order[1] != 1 || obs_order[2] != 3)
      begin n_err++; $display("FAIL seq_order got %p exp '{0, 1, 3}", obs_order); end
  endtask

  task automatic test_empty_mask();
    run_seq(4'b0000, '0, -1, 30);
    n_vec++;
    if (obs_order.size() != 0) begin n_err++; $display("FAIL empty_releases got %0d exp 0", obs_order.size()); end
  endtask

  task automatic test_watchdog();
    dly = '{1, 1, NEVER, 1};
    run_seq(4'b0100, WD_W'(10), -1, 30);
    n_vec += 2;
    if (obs_low[2] != 10) begin n_err++; $display("FAIL wd_run_cycles got %0d exp 10", obs_low[2]); end
    if (bus.error !== 1'b1 || bus.err_blk !== 2'd2)
      begin n_err++; $display("FAIL wd_abort got error=%b err_blk=%0d exp error=1 err_blk=2", bus.error, bus.err_blk); end
    dly[2] = 55;
    run_seq(4'b0100, '0, -1, 30);
    n_vec += 2;
    if (obs_low[2] != 56) begin n_err++; $display("FAIL wd_off_cycles got %0d exp 56", obs_low[2]); end
    if (bus.done !== 1'b1 || bus.error !== 1'b0)
      begin n_err++; $display("FAIL wd_off_final got done=%b error=%b exp done=1 error=0", bus.done, bus.error); end
  endtask

  task automatic test_done_timeout_tie();
    dly = '{7, NEVER, NEVER, NEVER};
    run_seq(4'b0001, WD_W'(8), -1, 30);
    n_vec++;
    if (bus.done !== 1'b1 || bus.error !== 1'b0)
      begin n_err++; $display("FAIL tie_done_wins got done=%b error=%b exp done=1 error=0", bus.done, bus.error); end
    run_seq(4'b0001, WD_W'(7), -1, 30);
    n_vec++;
    if (bus.error !== 1'b1 || bus.done !== 1'b0)
      begin n_err++; $display("FAIL tie_minus_one got done=%b error=%b exp done=0 error=1", bus.done, bus.error); end
  endtask

  task automatic test_abort_ignored();
    dly = '{4, 30, NEVER, NEVER};
    run_seq(4'b0011, '0, 1, 60);
  endtask

  task automatic test_random();
    logic [WD_W-1:0] wd;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < NBLK; i++) dly[i] = int'($urandom_range(25, 1));
      wd = ($urandom_range(1) == 0) ? '0 : WD_W'($urandom_range(30, 1));
      run_seq(NBLK'($urandom), wd, -1, 30);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_sequential();
    test_empty_mask();
    test_watchdog();
    test_done_timeout_tie();
    test_abort_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
